sensor_slot_decoder: RTL and testbench

SENSOR_SLOT_DECODER -- requirements
Module: sensor_slot_decoder

---
 rtl/sensor_slot_decoder_if.sv | 26 ++
 rtl/sensor_slot_decoder.sv | 113 +++++++++++
 tb/tb_sensor_slot_decoder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_slot_decoder_if.sv
// Bus bundle for sensor_slot_decoder: frame control, wired-OR slot pulse input,
// read port and frame status. The master drives the inputs; the decoder is the slave.
interface sensor_slot_decoder_if #(
    parameter int SLOT_BITS = 4,
    parameter int DATA_BITS = 8
);
    logic                        sample_en;
    logic                        slot_in;
    logic [SLOT_BITS-1:0]        rd_addr;
    logic [DATA_BITS-1:0]        rd_data;
    logic                        rd_hit;
    logic [(1<<SLOT_BITS)-1:0]   valid_map;
    logic                        busy;
    logic                        frame_done;
    logic                        dup_err;

    modport master (
        output sample_en, slot_in, rd_addr,
        input  rd_data, rd_hit, valid_map, busy, frame_done, dup_err
    );

    modport slave (
        input  sample_en, slot_in, rd_addr,
        output rd_data, rd_hit, valid_map, busy, frame_done, dup_err
    );
endinterface

// File: rtl/sensor_slot_decoder.sv
// Time-slot sensor decoder: a frame walks slot_cnt/data_cnt; a slot pulse latches data_cnt for
// that slot. Optional macro SLOT_DUP_DETECT_EN keeps the first pulse per frame and flags repeats.
module sensor_slot_decoder #(
    parameter int SLOT_BITS = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                  clk_division,
    input  logic                  rst_n,
    sensor_slot_decoder_if.slave  bus
);
    localparam int NSLOT = 1 << SLOT_BITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [SLOT_BITS-1:0]   slot_cnt_q, slot_cnt_d;
    logic [DATA_BITS-1:0]   data_cnt_q, data_cnt_d;
    logic [NSLOT-1:0]       valid_map_q, valid_map_d;
    logic [DATA_BITS-1:0]   mem_q [NSLOT];
    logic [DATA_BITS-1:0]   mem_d [NSLOT];
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   rd_hit_q, rd_hit_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   dup_err_q, dup_err_d;

    always_comb begin
        state_d      = state_q;
        slot_cnt_d   = slot_cnt_q;
        data_cnt_d   = data_cnt_q;
        valid_map_d  = valid_map_q;
        mem_d        = mem_q;
        dup_err_d    = dup_err_q;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        // Reads see the pre-edge array, so a same-edge capture returns old contents.
        rd_data_d    = mem_q[bus.rd_addr];
        rd_hit_d     = valid_map_q[bus.rd_addr];

        case (state_q)
            IDLE: begin
                if (bus.sample_en) begin
                    state_d     = RUN;
                    slot_cnt_d  = '0;
                    data_cnt_d  = '0;
                    valid_map_d = '0;
                    dup_err_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                busy_d     = 1'b1;
                slot_cnt_d = slot_cnt_q + SLOT_BITS'(1);
                if (slot_cnt_q == '1) begin
                    data_cnt_d = data_cnt_q + DATA_BITS'(1);
                    if (data_cnt_q == '1) begin
                        state_d      = DONE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end
                end
                if (bus.slot_in) begin
`ifdef SLOT_DUP_DETECT_EN
                    if (valid_map_q[slot_cnt_q]) begin
                        dup_err_d = 1'b1;
                    end else begin
                        mem_d[slot_cnt_q]       = data_cnt_q;
                        valid_map_d[slot_cnt_q] = 1'b1;
                    end
`else
                    mem_d[slot_cnt_q]       = data_cnt_q;
                    valid_map_d[slot_cnt_q] = 1'b1;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_division or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_cnt_q   <= '0;
            data_cnt_q   <= '0;
            valid_map_q  <= '0;
            mem_q        <= '{default: '0};
            rd_data_q    <= '0;
            rd_hit_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dup_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            data_cnt_q   <= data_cnt_d;
            valid_map_q  <= valid_map_d;
            mem_q        <= mem_d;
            rd_data_q    <= rd_data_d;
            rd_hit_q     <= rd_hit_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            dup_err_q    <= dup_err_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_hit     = rd_hit_q;
    assign bus.valid_map  = valid_map_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dup_err    = dup_err_q;
endmodule

// File: tb/tb_sensor_slot_decoder.sv
// Scoreboard bench for sensor_slot_decoder: a behavioural model of mem/valid_map predicts
// every read, expected reads are queued at drive time and popped one cycle later.
`timescale 1ns/1ps
module tb_sensor_slot_decoder;
    localparam int SB    = 4;
    localparam int DB    = 8;
    localparam int NS    = 1 << SB;
    localparam int FRAME = 1 << (SB + DB);

    logic clk_division = 1'b0;
    logic rst_n        = 1'b0;
    always #5 clk_division = ~clk_division;

    sensor_slot_decoder_if #(.SLOT_BITS(SB), .DATA_BITS(DB)) bus ();

    sensor_slot_decoder #(.SLOT_BITS(SB), .DATA_BITS(DB)) dut (
        .clk_division (clk_division),
        .rst_n        (rst_n),
        .bus          (bus)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic       h;
    } exp_t;

    exp_t       sb_q [$];
    logic [7:0] m_mem [NS];
    logic [15:0] m_vm;
    logic       m_dup;
    logic       pulses [FRAME];
    int         n_chk, n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_division);
        #1;
    endtask

    task automatic push_read(input int a);
        bus.rd_addr = a[SB-1:0];
        sb_q.push_back('{a: a[7:0], d: m_mem[a], h: m_vm[a]});
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk($sformatf("rd%0d_data", e.a), {24'd0, bus.rd_data}, {24'd0, e.d});
            chk($sformatf("rd%0d_hit", e.a), {31'd0, bus.rd_hit}, {31'd0, e.h});
        end
    endtask

    task automatic do_read(input int a);
        push_read(a);
        step();
        pop_check();
    endtask

    task automatic model_pulse(input int s, input int d);
`ifdef SLOT_DUP_DETECT_EN
        if (m_vm[s]) m_dup = 1'b1;
        else begin
            m_mem[s] = d[7:0];
            m_vm[s]  = 1'b1;
        end
`else
        m_mem[s] = d[7:0];
        m_vm[s]  = 1'b1;
`endif
    endtask

    task automatic clr_pulses();
        for (int k = 0; k < FRAME; k++) pulses[k] = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        bus.sample_en = 1'b1;
        step();
        bus.sample_en = 1'b0;
        m_vm  = '0;
        m_dup = 1'b0;
        chk({tag, "_start_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_start_vmap"}, {16'd0, bus.valid_map}, {16'd0, m_vm});
        chk({tag, "_start_dup"}, {31'd0, bus.dup_err}, {31'd0, m_dup});
    endtask

    // Full frame; rbw_k < 0 / se_k < 0 disable the same-edge read and mid-frame sample_en.
    task automatic run_frame(input string tag, input int rbw_k, input int rbw_a, input int se_k);
        start_frame(tag);
        for (int k = 0; k < FRAME; k++) begin
            bus.slot_in   = pulses[k];
            bus.sample_en = (k == se_k);
            if (k == rbw_k) push_read(rbw_a);
            if (pulses[k]) model_pulse(k % NS, k / NS);
            step();
            if (k == rbw_k) pop_check();
            if (k == FRAME - 2) begin
                chk({tag, "_last_run_busy"}, {31'd0, bus.busy}, 32'd1);
                chk({tag, "_last_run_done"}, {31'd0, bus.frame_done}, 32'd0);
            end
        end
        bus.slot_in   = 1'b0;
        bus.sample_en = 1'b0;
        chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd1);
        chk({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_vmap"}, {16'd0, bus.valid_map}, {16'd0, m_vm});
        chk({tag, "_dup"}, {31'd0, bus.dup_err}, {31'd0, m_dup});
        step();
        chk({tag, "_done_pulse_end"}, {31'd0, bus.frame_done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        n_chk = 0;
        n_fail = 0;
        bus.sample_en = 1'b0;
        bus.slot_in   = 1'b0;
        bus.rd_addr   = '0;
        for (int i = 0; i < NS; i++) m_mem[i] = 8'h00;
        m_vm  = '0;
        m_dup = 1'b0;

        #12;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.frame_done}, 32'd0);
        chk("rst_vmap", {16'd0, bus.valid_map}, 32'd0);
        chk("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
        chk("rst_rd_hit", {31'd0, bus.rd_hit}, 32'd0);
        chk("rst_dup", {31'd0, bus.dup_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Frame 1: single pulse, sensor 3 at sample 0xA5.
        clr_pulses();
        pulses[8'hA5 * NS + 3] = 1'b1;
        run_frame("f1", -1, 0, -1);
        do_read(3);
        do_read(0);

        // slot_in while idle must not capture.
        bus.slot_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.slot_in = 1'b0;
        chk("idle_slot_vmap", {16'd0, bus.valid_map}, {16'd0, m_vm});
        do_read(0);

        // Frame 2: boundary captures at first and last RUN cycles.
        clr_pulses();
        pulses[0]         = 1'b1;
        pulses[FRAME - 1] = 1'b1;
        run_frame("f2", -1, 0, -1);
        do_read(0);
        do_read(15);
        do_read(3);

        // Frame 3: no pulses; data persists, hits clear.
        clr_pulses();
        run_frame("f3", -1, 0, -1);
        do_read(0);
        do_read(15);
        do_read(3);

        // Frame 4: duplicate pulses at sensor 5, same-edge read, ignored sample_en.
        clr_pulses();
        pulses[8'h10 * NS + 5] = 1'b1;
        pulses[8'h20 * NS + 5] = 1'b1;
        run_frame("f4", 8'h10 * NS + 5, 5, 100);
        do_read(5);

        // Frame 5: reset mid-frame at data_cnt 0x80.
        start_frame("f5");
        for (int k = 0; k < 8'h80 * NS; k++) begin
            bus.slot_in = (k == 7);
            if (k == 7) model_pulse(7, 0);
            step();
        end
        bus.slot_in = 1'b0;
        #2 rst_n = 1'b0;
        for (int i = 0; i < NS; i++) m_mem[i] = 8'h00;
        m_vm  = '0;
        m_dup = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.frame_done}, 32'd0);
        chk("abort_vmap", {16'd0, bus.valid_map}, 32'd0);
        chk("abort_rd_data", {24'd0, bus.rd_data}, 32'd0);
        step();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (bus.frame_done || bus.busy) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        do_read(7);
        do_read(3);
        do_read(15);

        // Fresh frame after reset release.
        clr_pulses();
        pulses[9 * NS + 2] = 1'b1;
        run_frame("f6", -1, 0, -1);
        do_read(2);
        do_read(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
